urv_dmem_responder: RTL

Data-memory responder: the slave end of the uRV CPU data-memory interface (dm_addr/dm_data_s/dm_data_select/dm_load/dm_store in, dm_data_l/dm_load_done/dm_store_done out). It holds a local byte-writable word RAM and answers each request after a programmable number of wait states. An external contention stall can hold the wait-state counter. Out-of-range accesses are flagged. Used as the CPU's on-chip data RAM and as the reference slave in CPU benches.

---
 rtl/urv_dmem_pkg.sv | 27 ++
 rtl/urv_dmem_if.sv | 25 ++
 rtl/urv_dmem_ram.sv | 25 ++
 rtl/urv_dmem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/urv_dmem_pkg.sv
// Shared types and helpers for the uRV data-memory responder.
package urv_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  typedef enum logic {
    LOAD,
    STORE
  } dmem_req_e;

  localparam logic [31:0] c_err_fill = 32'h0;

  // Address width needed to index 'value' entries (minimum 1).
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/urv_dmem_if.sv
// uRV CPU data-memory bus; master is the CPU side, slave is the responder.
// Handshake: dm_load_i/dm_store_i are one-cycle strobes accepted only while
// the slave is idle; each accepted strobe yields exactly one done pulse.
interface urv_dmem_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        bus_err_o;
  logic        busy_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    input  dm_data_l_o, dm_load_done_o, dm_store_done_o, bus_err_o, busy_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_load_i, dm_store_i,
    output dm_data_l_o, dm_load_done_o, dm_store_done_o, bus_err_o, busy_o
  );
endinterface

// File: rtl/urv_dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Kept in its own module so FPGA tools infer block RAM cleanly.
module urv_dmem_ram
  import urv_dmem_pkg::*;
#(
  parameter int unsigned depth = 4096
) (
  input  logic                    clk_i,
  input  logic [clog2(depth)-1:0] addr,
  input  logic [31:0]             wdata,
  input  logic [3:0]              we,
  output logic [31:0]             rdata
);

  logic [31:0] mem [depth];

  // Read-before-write: rdata returns the word as it was before this edge.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/urv_dmem_responder.sv
// Data-memory responder with programmable wait states and range checking.
// Optional URV_DMEM_ERR_COUNT_EN adds a saturating bus-error counter.
module urv_dmem_responder
  import urv_dmem_pkg::*;
#(
  parameter int unsigned g_size_words  = 4096,
  parameter int unsigned g_wait_states = 0,
  parameter logic [31:0] g_base_addr   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ext_stall_i,
`ifdef URV_DMEM_ERR_COUNT_EN
  input  logic        err_count_clr_i,
  output logic [15:0] err_count_o,
`endif
  urv_dmem_if.slave   bus
);

  localparam int unsigned IDXW = clog2(g_size_words);
  localparam logic [3:0]  c_last = (g_wait_states > 0) ? 4'(g_wait_states - 1) : 4'd0;

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  dmem_req_e       type_q, type_d;
  logic            in_range_q, in_range_d;
  logic            proto_err_q, proto_err_d;
  logic            load_done_q, load_done_d;
  logic            store_done_q, store_done_d;
  logic            bus_err_q, bus_err_d;
  logic            busy_q, busy_d;
  logic            resp_load_q, resp_load_d;

  logic [29:0]     word_off;
  logic            in_range_now;
  logic            any_req;
  logic            go_resp;
  logic [IDXW-1:0] ram_addr;
  logic [3:0]      ram_we;
  logic [31:0]     ram_rdata;
  logic            unused_addr_lsb;

  // Below-base addresses wrap to huge offsets and fall out of range.
  assign word_off        = bus.dm_addr_i[31:2] - g_base_addr[31:2];
  assign in_range_now    = (word_off < 30'(g_size_words));
  assign any_req         = bus.dm_load_i | bus.dm_store_i;
  assign unused_addr_lsb = ^bus.dm_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    type_d       = type_q;
    in_range_d   = in_range_q;
    proto_err_d  = proto_err_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    bus_err_d    = 1'b0;
    busy_d       = busy_q;
    resp_load_d  = 1'b0;
    go_resp      = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d       = word_off[IDXW-1:0];
          wdata_d     = bus.dm_data_s_i;
          sel_d       = bus.dm_data_select_i;
          type_d      = (bus.dm_load_i && !bus.dm_store_i) ? LOAD : STORE;
          in_range_d  = in_range_now;
          proto_err_d = bus.dm_load_i & bus.dm_store_i;
          cnt_d       = 4'd0;
          if (g_wait_states == 0) begin
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            busy_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (any_req) bus_err_d = 1'b1;
        if (!ext_stall_i) begin
          if (cnt_q == c_last) begin
            go_resp = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      RESP: begin
        if (any_req) bus_err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed on the way into RESP.
    if (go_resp) begin
      state_d      = RESP;
      busy_d       = 1'b0;
      load_done_d  = (type_d == LOAD);
      store_done_d = (type_d == STORE);
      resp_load_d  = (type_d == LOAD);
      bus_err_d    = bus_err_d | !in_range_d | proto_err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      sel_q        <= 4'h0;
      type_q       <= LOAD;
      in_range_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      resp_load_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      type_q       <= type_d;
      in_range_q   <= in_range_d;
      proto_err_q  <= proto_err_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      bus_err_q    <= bus_err_d;
      busy_q       <= busy_d;
      resp_load_q  <= resp_load_d;
    end
  end

  // In IDLE the RAM reads the live address so zero-wait loads have data in RESP.
  assign ram_addr = (state_q == IDLE) ? word_off[IDXW-1:0] : idx_q;
  assign ram_we   = (state_q == RESP && type_q == STORE && in_range_q && !proto_err_q)
                    ? sel_q : 4'h0;

  urv_dmem_ram #(
    .depth (g_size_words)
  ) u_ram (
    .clk_i (clk_i),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .we    (ram_we),
    .rdata (ram_rdata)
  );

  assign bus.dm_data_l_o     = resp_load_q ? (in_range_q ? ram_rdata : c_err_fill) : 32'h0;
  assign bus.dm_load_done_o  = load_done_q;
  assign bus.dm_store_done_o = store_done_q;
  assign bus.bus_err_o       = bus_err_q;
  assign bus.busy_o          = busy_q;

`ifdef URV_DMEM_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_count_clr_i) begin
      err_cnt_d = bus_err_q ? 16'd1 : 16'd0;
    end else if (bus_err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= 16'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule
